// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv32i datapath: load/store width codes, the
// data-memory FSM state type and the access-legality / byte-lane helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  // Stores exist only as sb/sh/sw; the unsigned codes are load-only.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    be = '0;
    case (f3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to the RV32I load code.
import riscv_pkg::*;

module load_extend (
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = word[{byte_off, 3'b000} +: 8];
    sel_h = byte_off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    value = {{24{sel_b[7]}}, sel_b};
      F3_BU:   value = {24'h000000, sel_b};
      F3_H:    value = {{16{sel_h[15]}}, sel_h};
      F3_HU:   value = {16'h0000, sel_h};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-lane data memory with req/done handshake, programmable wait states and
// a fault response for misaligned or illegal accesses.
import riscv_pkg::*;

module data_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT = 4'(LATENCY);

  mem_state_t      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;
  logic            busy_q, busy_d;

  logic [3:0][7:0] mem [DEPTH_WORDS];
  logic [AW-1:0]   idx;
  logic [31:0]     rd_word;
  logic [31:0]     ld_value;
  logic            access;
  logic            wr_en;
  logic [3:0]      be;
  logic [3:0][7:0] wlanes;

  // Address bits above the array size wrap silently, so they are never latched.
  logic unused_bits;
  assign unused_bits = ^{addr[31:AW+2], (INIT_FILE != "")};

  assign idx     = addr_q[AW+1:2];
  assign rd_word = mem[idx];
  assign access  = (state_q == WAIT) && (cnt_q == '0);
  assign wr_en   = access && we_q;

  load_extend u_load_extend (
    .word     (rd_word),
    .byte_off (addr_q[1:0]),
    .funct3   (f3_q),
    .value    (ld_value)
  );

  always_comb begin
    be = byte_enables(f3_q, addr_q[1:0]);
    case (f3_q)
      F3_B:    wlanes = {4{wdata_q[7:0]}};
      F3_H:    wlanes = {2{wdata_q[15:0]}};
      default: wlanes = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          f3_d    = funct3;
          addr_d  = addr[AW+1:0];
          wdata_d = wdata;
          if (access_legal(we, funct3, addr[1:0])) begin
            state_d = WAIT;
            cnt_d   = LAT;
          end else begin
            state_d = RESP;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          done_d  = 1'b1;
          if (!we_q) rdata_d = ld_value;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
    end
  end

  // Gating on reset makes a reset coincident with the access edge suppress the write.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i] <= wlanes[i];
      end
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: vector table on a LATENCY=1 instance plus
// busy-ignore, reset-abort and latency sequences across LATENCY=0/1/15.
import riscv_pkg::*;

module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_m = 1'b0, req_l = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;

  logic [31:0] rdata_m, rdata_0, rdata_15;
  logic        busy_m, busy_0, busy_15;
  logic        done_m, done_0, done_15;
  logic        fault_m, fault_0, fault_15;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory #(.DEPTH_WORDS(64), .LATENCY(1)) dut_m (
    .clk(clk), .reset(reset), .req(req_m), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata_m), .busy(busy_m), .done(done_m), .fault(fault_m));

  data_memory #(.DEPTH_WORDS(64), .LATENCY(0)) dut_0 (
    .clk(clk), .reset(reset), .req(req_l), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata_0), .busy(busy_0), .done(done_0), .fault(fault_0));

  data_memory #(.DEPTH_WORDS(64), .LATENCY(15)) dut_15 (
    .clk(clk), .reset(reset), .req(req_l), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata_15), .busy(busy_15), .done(done_15), .fault(fault_15));

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        fault;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [26];

  task automatic chk(input string what, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h exp=%h", what, idx, got, exp);
    end
  endtask

  // Lat counts edges after the request edge until done is seen (0 = same cycle).
  task automatic run_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic flt,
                        output logic busy_e, output logic pulse_ok);
    @(negedge clk);
    req_m = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge clk); #1;
    req_m = 1'b0;
    busy_e = busy_m;
    lat = -1; flt = 1'b0; pulse_ok = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      if (done_m) begin
        lat = n; flt = fault_m;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
      pulse_ok = !done_m;
    end
  endtask

  int   lat, lat_m, lat_0, lat_15, ndone;
  logic flt, busy_e, pulse_ok;
  logic [31:0] rd_at_done;

  initial begin
    vt[0]  = '{1'b1, F3_W,   32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_0000};
    vt[1]  = '{1'b0, F3_W,   32'h0000_0010, 32'h0,         2, 1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, F3_B,   32'h0000_0013, 32'h1234_5680, 2, 1'b0, 32'hDEAD_BEEF};
    vt[3]  = '{1'b0, F3_B,   32'h0000_0013, 32'h0,         2, 1'b0, 32'hFFFF_FF80};
    vt[4]  = '{1'b0, F3_BU,  32'h0000_0013, 32'h0,         2, 1'b0, 32'h0000_0080};
    vt[5]  = '{1'b0, F3_W,   32'h0000_0010, 32'h0,         2, 1'b0, 32'h80AD_BEEF};
    vt[6]  = '{1'b0, F3_H,   32'h0000_0011, 32'h0,         0, 1'b1, 32'h80AD_BEEF};
    vt[7]  = '{1'b1, F3_W,   32'h0000_0012, 32'hFFFF_FFFF, 0, 1'b1, 32'h80AD_BEEF};
    vt[8]  = '{1'b0, F3_W,   32'h0000_0010, 32'h0,         2, 1'b0, 32'h80AD_BEEF};
    vt[9]  = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,         0, 1'b1, 32'h80AD_BEEF};
    vt[10] = '{1'b1, F3_W,   32'h0000_0014, 32'h1122_3344, 2, 1'b0, 32'h80AD_BEEF};
    vt[11] = '{1'b1, F3_H,   32'h0000_0016, 32'hAAAA_C3A5, 2, 1'b0, 32'h80AD_BEEF};
    vt[12] = '{1'b0, F3_W,   32'h0000_0014, 32'h0,         2, 1'b0, 32'hC3A5_3344};
    vt[13] = '{1'b0, F3_W,   32'h0000_0110, 32'h0,         2, 1'b0, 32'h80AD_BEEF};
    vt[14] = '{1'b0, F3_H,   32'h0000_0016, 32'h0,         2, 1'b0, 32'hFFFF_C3A5};
    vt[15] = '{1'b0, F3_HU,  32'h0000_0014, 32'h0,         2, 1'b0, 32'h0000_3344};
    vt[16] = '{1'b0, F3_B,   32'h0000_0015, 32'h0,         2, 1'b0, 32'h0000_0033};
    vt[17] = '{1'b1, F3_BU,  32'h0000_0014, 32'h0,         0, 1'b1, 32'h0000_0033};
    vt[18] = '{1'b1, 3'b110, 32'h0000_0014, 32'h0,         0, 1'b1, 32'h0000_0033};
    vt[19] = '{1'b0, F3_W,   32'h0000_0014, 32'h0,         2, 1'b0, 32'hC3A5_3344};
    vt[20] = '{1'b1, F3_W,   32'hFFFF_FF20, 32'h5A5A_A5A5, 2, 1'b0, 32'hC3A5_3344};
    vt[21] = '{1'b0, F3_W,   32'h0000_0020, 32'h0,         2, 1'b0, 32'h5A5A_A5A5};
    vt[22] = '{1'b0, F3_B,   32'h0000_0012, 32'h0,         2, 1'b0, 32'hFFFF_FFAD};
    vt[23] = '{1'b0, 3'b111, 32'h0000_0000, 32'h0,         0, 1'b1, 32'hFFFF_FFAD};
    vt[24] = '{1'b1, F3_H,   32'h0000_0013, 32'h0,         0, 1'b1, 32'hFFFF_FFAD};
    vt[25] = '{1'b0, F3_HU,  32'h0000_0012, 32'h0,         2, 1'b0, 32'h0000_80AD};

    #1;
    chk("rst_rdata", 0, rdata_m, 32'h0);
    chk("rst_busy",  0, {31'b0, busy_m},  32'h0);
    chk("rst_done",  0, {31'b0, done_m},  32'h0);
    chk("rst_fault", 0, {31'b0, fault_m}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      run_op(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, lat, flt, busy_e, pulse_ok);
      chk("lat",   i, 32'(lat), 32'(vt[i].lat));
      chk("fault", i, {31'b0, flt}, {31'b0, vt[i].fault});
      chk("rdata", i, rdata_m, vt[i].rdata);
      chk("busy",  i, {31'b0, busy_e}, 32'h1);
      chk("pulse", i, {31'b0, pulse_ok}, 32'h1);
    end

    // A store request arriving during WAIT must be dropped, not queued.
    @(negedge clk);
    req_m = 1'b1; we = 1'b0; funct3 = F3_B; addr = 32'h10; wdata = 32'h0;
    @(posedge clk); #1;
    req_m = 1'b0;
    @(negedge clk);
    req_m = 1'b1; we = 1'b1; funct3 = F3_W; addr = 32'h10; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_m = 1'b0;
    ndone = 0; rd_at_done = 32'h0;
    for (int n = 0; n < 10; n++) begin
      if (done_m) begin
        ndone++;
        rd_at_done = rdata_m;
      end
      @(posedge clk); #1;
    end
    chk("ign_ndone", 0, 32'(ndone), 32'd1);
    chk("ign_rdata", 0, rd_at_done, 32'hFFFF_FFEF);
    run_op(1'b0, F3_W, 32'h10, 32'h0, lat, flt, busy_e, pulse_ok);
    chk("ign_word", 0, rdata_m, 32'h80AD_BEEF);

    // Reset during WAIT aborts the store.
    @(negedge clk);
    req_m = 1'b1; we = 1'b1; funct3 = F3_W; addr = 32'h20; wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    req_m = 1'b0;
    chk("abort_busy", 0, {31'b0, busy_m}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_rdata", 0, rdata_m, 32'h0);
    chk("abort_busy",  1, {31'b0, busy_m},  32'h0);
    chk("abort_done",  0, {31'b0, done_m},  32'h0);
    chk("abort_fault", 0, {31'b0, fault_m}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, F3_W, 32'h20, 32'h0, lat, flt, busy_e, pulse_ok);
    chk("abort_lat",  0, 32'(lat), 32'd2);
    chk("abort_word", 0, rdata_m, 32'h5A5A_A5A5);

    // Same load issued to LATENCY 1, 0 and 15 instances.
    @(negedge clk);
    req_m = 1'b1; req_l = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h10; wdata = 32'h0;
    @(posedge clk); #1;
    req_m = 1'b0; req_l = 1'b0;
    lat_m = -1; lat_0 = -1; lat_15 = -1;
    for (int n = 0; n <= 40; n++) begin
      if (done_m  && lat_m  < 0) lat_m  = n;
      if (done_0  && lat_0  < 0) lat_0  = n;
      if (done_15 && lat_15 < 0) lat_15 = n;
      @(posedge clk); #1;
    end
    chk("lat_l1",  0, 32'(lat_m),  32'd2);
    chk("lat_l0",  0, 32'(lat_0),  32'd1);
    chk("lat_l15", 0, 32'(lat_15), 32'd16);
    chk("lat_rdata", 0, rdata_m, 32'h80AD_BEEF);
    chk("lat_busy15", 0, {31'b0, busy_15}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
